// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the instruction-fetch slice.
//   - fetch_state_t : fetch FSM state encoding
//   - pcsrc_t       : next-PC source codes driven by the decode/execute stages
//   - NOP_DEFAULT   : default bubble instruction
//   - word_align()  : clears the byte-offset bits of an address
// Build option: FETCH_INTR_EN (see fetch_unit.sv).
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_REQ   = 2'b01,
        ST_VALID = 2'b10,
        ST_KILL  = 2'b11
    } fetch_state_t;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_JMP = 2'b10,
        PCSRC_RSV = 2'b11
    } pcsrc_t;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_npc_sel.sv
// fetch_npc_sel: combinational next-PC priority mux.
// Priority: intr (EXC_VECTOR) > eret (epc) > branch/jump > pc+4.
// Build option FETCH_INTR_EN: when undefined the intr/eret/epc ports and the
// EXC_VECTOR parameter do not exist; only pcsrc and pc+4 are considered.
// Ports:
//   pc        in  32  current PC
//   pcsrc     in   2  next-PC source code (11 treated as sequential)
//   bpc, jpc  in  32  branch / jump targets
//   intr,eret in   1  redirect requests (FETCH_INTR_EN only)
//   epc       in  32  eret target (FETCH_INTR_EN only)
//   pc_seq    out 32  pc + 4, wrapping mod 2^32
//   pc_redir  out 32  redirect target, valid when redirect = 1
//   redirect  out  1  a redirect source is active this cycle
module fetch_npc_sel
    import fetch_unit_pkg::*;
(
`ifdef FETCH_INTR_EN
    input  logic        intr,
    input  logic        eret,
    input  logic [31:0] epc,
`endif
    input  logic [31:0] pc,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    output logic [31:0] pc_seq,
    output logic [31:0] pc_redir,
    output logic        redirect
);

`ifdef FETCH_INTR_EN
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0008;
`endif

    always_comb begin
        pc_seq   = pc + 32'd4;
        pc_redir = pc_seq;
        redirect = 1'b0;

        case (pcsrc)
            PCSRC_BR: begin
                redirect = 1'b1;
                pc_redir = bpc;
            end
            PCSRC_JMP: begin
                redirect = 1'b1;
                pc_redir = jpc;
            end
            default: ;
        endcase

`ifdef FETCH_INTR_EN
        // Later assignments win, giving intr the highest priority.
        if (eret) begin
            redirect = 1'b1;
            pc_redir = epc;
        end
        if (intr) begin
            redirect = 1'b1;
            pc_redir = EXC_VECTOR;
        end
`endif
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, runs the imem req/ready
// handshake and presents (if_pc, if_pc4, if_inst) to the IF/ID register.
// Build option FETCH_INTR_EN: when defined, intr/eret redirects are honoured;
// when undefined, intr, eret and epc are ignored.
// Ports:
//   clk, clrn            clock, asynchronous active-low reset
//   stall                downstream hold of the current instruction
//   pcsrc, bpc, jpc      branch/jump selection and targets
//   intr, eret, epc      interrupt / return-from-exception redirects
//   imem_req, imem_addr  fetch request and word-aligned address
//   imem_rdata, imem_ready  memory data and completion
//   if_pc, if_pc4, if_inst  IF-side bundle (if_inst = NOP_INST when invalid)
//   fetch_stall          1 when if_inst is not valid
//
// state    | meaning
// ST_BOOT  | first cycle after reset release, no request
// ST_REQ   | request for pc outstanding, waiting for imem_ready
// ST_VALID | instruction captured, presented on if_inst
// ST_KILL  | redirected while a request was pending; drain it at kill_addr
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0008,
    parameter logic [31:0] NOP_INST   = NOP_DEFAULT
)(
    input  logic        clk,
    input  logic        clrn,
    input  logic        stall,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic        intr,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic [31:0] if_inst,
    output logic        fetch_stall
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic [31:0]  inst;
    logic [31:2]  kill_addr;
    logic         inst_capture;
    logic         kill_capture;
    logic [31:0]  pc_seq;
    logic [31:0]  pc_redir;
    logic         redirect;

`ifdef FETCH_INTR_EN
    fetch_npc_sel #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_npc_sel (
        .intr     (intr),
        .eret     (eret),
        .epc      (epc),
        .pc       (pc),
        .pcsrc    (pcsrc),
        .bpc      (bpc),
        .jpc      (jpc),
        .pc_seq   (pc_seq),
        .pc_redir (pc_redir),
        .redirect (redirect)
    );
`else
    fetch_npc_sel u_npc_sel (
        .pc       (pc),
        .pcsrc    (pcsrc),
        .bpc      (bpc),
        .jpc      (jpc),
        .pc_seq   (pc_seq),
        .pc_redir (pc_redir),
        .redirect (redirect)
    );

    // Interrupt inputs are deliberately left dangling in this build.
    logic unused_intr_path;
    assign unused_intr_path = ^{intr, eret, epc, EXC_VECTOR};
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= ST_BOOT;
            pc        <= RESET_PC;
            inst      <= NOP_INST;
            kill_addr <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (inst_capture)
                inst <= imem_rdata;
            if (kill_capture)
                kill_addr <= pc[31:2];
        end
    end

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        inst_capture = 1'b0;
        kill_capture = 1'b0;
        imem_req     = 1'b0;

        case (state)
            ST_BOOT: begin
                state_next = ST_REQ;
            end
            ST_REQ: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pc_next = pc_redir;
                    // A completing request is simply dropped; a pending one
                    // must still be drained at its original address.
                    if (!imem_ready) begin
                        kill_capture = 1'b1;
                        state_next   = ST_KILL;
                    end
                end else if (imem_ready) begin
                    inst_capture = 1'b1;
                    state_next   = ST_VALID;
                end
            end
            ST_VALID: begin
                if (redirect) begin
                    pc_next    = pc_redir;
                    state_next = ST_REQ;
                end else if (!stall) begin
                    pc_next    = pc_seq;
                    state_next = ST_REQ;
                end
            end
            ST_KILL: begin
                imem_req = 1'b1;
                if (redirect)
                    pc_next = pc_redir;
                if (imem_ready)
                    state_next = ST_REQ;
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    assign if_pc       = pc;
    assign if_pc4      = pc_seq;
    assign imem_addr   = (state == ST_KILL) ? {kill_addr, 2'b00} : word_align(pc);
    assign fetch_stall = (state != ST_VALID);
    assign if_inst     = (state == ST_VALID) ? inst : NOP_INST;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0008;
    localparam logic [31:0] NOP_INST   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  pcsrc = 2'b00;
    logic [31:0] bpc = '0;
    logic [31:0] jpc = '0;
    logic        intr = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] if_inst;
    logic        fetch_stall;

    int checks = 0;
    int failures = 0;

    // Reference model: where the fetch stage is in its life cycle, expressed
    // as "is booting / has an instruction / is draining a stale request".
    logic [31:0] m_pc;
    logic        m_boot;
    logic        m_valid;
    logic        m_kill;
    logic [31:0] m_kaddr;
    logic [31:0] m_inst;

    fetch_unit #(
        .RESET_PC   (RESET_PC),
        .EXC_VECTOR (EXC_VECTOR),
        .NOP_INST   (NOP_INST)
    ) dut (
        .clk         (clk),
        .clrn        (clrn),
        .stall       (stall),
        .pcsrc       (pcsrc),
        .bpc         (bpc),
        .jpc         (jpc),
        .intr        (intr),
        .eret        (eret),
        .epc         (epc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .if_pc       (if_pc),
        .if_pc4      (if_pc4),
        .if_inst     (if_inst),
        .fetch_stall (fetch_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC0DE_0001;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pc    = RESET_PC;
        m_boot  = 1'b1;
        m_valid = 1'b0;
        m_kill  = 1'b0;
        m_kaddr = '0;
        m_inst  = NOP_INST;
    endtask

    task automatic check_all();
        logic [31:0] aligned;
        aligned = {m_pc[31:2], 2'b00};
        chk("if_pc", if_pc, m_pc);
        chk("if_pc4", if_pc4, m_pc + 32'd4);
        chk("imem_req", {31'b0, imem_req}, {31'b0, !m_boot && !m_valid});
        chk("imem_addr", imem_addr, m_kill ? m_kaddr : aligned);
        chk("fetch_stall", {31'b0, fetch_stall}, {31'b0, !m_valid});
        chk("if_inst", if_inst, m_valid ? m_inst : NOP_INST);
    endtask

    task automatic update_model();
        logic        redir;
        logic [31:0] tgt;
        redir = (pcsrc == 2'b01) || (pcsrc == 2'b10);
        tgt   = (pcsrc == 2'b01) ? bpc : jpc;
`ifdef FETCH_INTR_EN
        if (eret) begin
            redir = 1'b1;
            tgt   = epc;
        end
        if (intr) begin
            redir = 1'b1;
            tgt   = EXC_VECTOR;
        end
`endif
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_kill) begin
            if (redir)
                m_pc = tgt;
            if (imem_ready)
                m_kill = 1'b0;
        end else if (m_valid) begin
            if (redir) begin
                m_pc    = tgt;
                m_valid = 1'b0;
            end else if (!stall) begin
                m_pc    = m_pc + 32'd4;
                m_valid = 1'b0;
            end
        end else begin
            if (redir) begin
                if (!imem_ready) begin
                    m_kaddr = {m_pc[31:2], 2'b00};
                    m_kill  = 1'b1;
                end
                m_pc = tgt;
            end else if (imem_ready) begin
                m_inst  = mem_word({m_pc[31:2], 2'b00});
                m_valid = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        check_all();
        update_model();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] exp_pc;

        // Reset held
        m_reset();
        #2;
        check_all();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_inst", if_inst, NOP_INST);
        @(negedge clk);
        clrn = 1'b1;

        // Straight-line fetch with memory always ready
        imem_ready = 1'b1;
        cycle();                          // boot
        chk("boot_addr0", imem_addr, 32'h0);
        for (int i = 0; i < 5; i++) cycle();
        chk("valid_at_8_pc", if_pc, 32'h8);
        chk("valid_at_8_inst", if_inst, mem_word(32'h8));

        // Stall holds pc and instruction
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_hold_pc", if_pc, 32'h8);
            chk("stall_hold_req", {31'b0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        cycle();
        chk("after_stall_addr", imem_addr, 32'hC);

        // Branch while a request is pending -> kill, drain old address
        imem_ready = 1'b0;
        pcsrc = 2'b01;
        bpc = 32'h40;
        cycle();
        pcsrc = 2'b00;
        chk("kill_old_addr", imem_addr, 32'hC);
        cycle();
        cycle();
        chk("kill_still_req", {31'b0, imem_req}, 32'd1);
        imem_ready = 1'b1;
        cycle();
        chk("after_kill_addr", imem_addr, 32'h40);
        chk("after_kill_stall", {31'b0, fetch_stall}, 32'd1);
        cycle();
        chk("branch_inst", if_inst, mem_word(32'h40));

        // intr and jump together
        intr = 1'b1;
        pcsrc = 2'b10;
        jpc = 32'h200;
        cycle();
        intr = 1'b0;
        pcsrc = 2'b00;
`ifdef FETCH_INTR_EN
        exp_pc = EXC_VECTOR;
`else
        exp_pc = 32'h200;
`endif
        chk("intr_vs_jump", if_pc, exp_pc);
        cycle();

        // eret during stall
        stall = 1'b1;
        eret = 1'b1;
        epc = 32'h100;
        cycle();
        eret = 1'b0;
`ifdef FETCH_INTR_EN
        chk("eret_over_stall", imem_addr, 32'h100);
`else
        chk("eret_ignored", if_pc, exp_pc);
`endif
        stall = 1'b0;
        cycle();
        cycle();

        // Wrap of pc+4
        pcsrc = 2'b10;
        jpc = 32'hFFFF_FFFC;
        cycle();
        pcsrc = 2'b00;
        for (int i = 0; i < 4 && !m_valid; i++) cycle();
        chk("wrap_valid", {31'b0, fetch_stall}, 32'd0);
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", if_pc4, 32'h0);
        cycle();
        chk("wrap_next", if_pc, 32'h0);

        // Reset while a request is outstanding
        imem_ready = 1'b0;
        clrn = 1'b0;
        #1;
        m_reset();
        chk("midreq_rst_req", {31'b0, imem_req}, 32'd0);
        check_all();
        @(negedge clk);
        clrn = 1'b1;
        cycle();

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            stall      = ($urandom_range(0, 2) == 0);
            imem_ready = $urandom_range(0, 1) == 1;
            r          = $urandom_range(0, 9);
            pcsrc      = (r == 6) ? 2'b01 : (r == 7) ? 2'b10 : (r == 8) ? 2'b11 : 2'b00;
            r          = $urandom;
            bpc        = {r[31:2], 2'b00};
            r          = $urandom;
            jpc        = {r[31:2], 2'b00};
            r          = $urandom;
            epc        = {r[31:2], 2'b00};
            intr       = ($urandom_range(0, 15) == 0);
            eret       = ($urandom_range(0, 11) == 0);
            cycle();
        end
        stall = 1'b0;
        intr = 1'b0;
        eret = 1'b0;
        pcsrc = 2'b00;
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that produces the IF-side bundle (if_pc, if_pc4, if_inst) consumed by the IF/ID pipeline register.
- Owns the PC register and next-PC selection: sequential, branch, jump, interrupt vector, eret.
- Talks to instruction memory over a req/ready handshake.
- Honours the downstream stall and presents a NOP bubble whenever no valid instruction is available.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h0000_0008, interrupt entry address
NOP_INST, 32'h0000_0000, bubble instruction driven when if_inst is not valid

Ports:
clk  in  1  clock
clrn  in  1  asynchronous active-low reset
stall  in  1  downstream stall from hazard unit; 1 = hold current instruction
pcsrc  in  2  00 seq, 01 branch, 10 jump, 11 reserved (treated as seq)
bpc  in  32  branch target
jpc  in  32  jump target
intr  in  1  interrupt redirect request (one-cycle pulse)
eret  in  1  return-from-exception redirect request
epc  in  32  eret target
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, word aligned
imem_rdata  in  32  instruction data, valid when imem_ready=1
imem_ready  in  1  memory completes request this cycle
if_pc  out  32  PC of the instruction on if_inst
if_pc4  out  32  if_pc+4
if_inst  out  32  fetched instruction or NOP_INST
fetch_stall  out  1  1 = if_inst not valid this cycle

Behaviour:
- Reset (clrn=0, async): pc=RESET_PC, state=ST_BOOT, imem_req=0, if_inst=NOP_INST, fetch_stall=1.
- Combinational outputs:
  - if_pc = pc; if_pc4 = pc + 4, mod 2^32 (wrap from 32'hFFFF_FFFC to 0 with no flag).
  - imem_addr = {pc[31:2],2'b00}.
  - imem_req = 1 only in ST_REQ and ST_KILL.
  - fetch_stall = (state != ST_VALID).
  - if_inst = captured instruction in ST_VALID, else NOP_INST.
- States:
  - ST_BOOT: one cycle after reset release -> ST_REQ.
  - ST_REQ:
    - Hold imem_req=1 and a stable imem_addr until imem_ready=1.
    - On ready, capture imem_rdata -> ST_VALID.
  - ST_VALID:
    - stall=1: hold pc and instruction.
    - stall=0: apply next-PC -> ST_REQ.
  - ST_KILL:
    - An outstanding request has been invalidated by a redirect.
    - Keep imem_req=1 with the original address until imem_ready=1, discard data -> ST_REQ at the new pc.
    - The captured old address is held in a kill_addr register.
- Next-PC priority: intr (EXC_VECTOR) > eret (epc) > pcsrc branch/jump > pc+4.
- Redirects (intr, eret, pcsrc=01/10):
  - Accepted in every state except ST_BOOT.
  - Override stall, and load pc the same cycle.
  - In ST_REQ with imem_ready=0 -> ST_KILL.
  - In ST_REQ with imem_ready=1 -> data dropped -> ST_REQ.
  - In ST_VALID -> ST_REQ, captured instruction dropped.
  - In ST_KILL: pc updated again, remain ST_KILL.
- Sequential advance (pc+4) happens only on ST_VALID with stall=0 and no redirect.
- Latency: minimum 2 cycles per instruction (REQ with ready, then VALID).
- Reset mid-request: the request is abandoned immediately. The memory side must tolerate req dropping.

Optional Feature:
- FETCH_INTR_EN defined: intr/eret redirects are honoured as above.
- Undefined: intr, eret and epc are ignored (no logic generated). Next-PC sources are pcsrc and pc+4 only.

Decomposition:
- Shared package: state encoding (ST_BOOT, ST_REQ, ST_VALID, ST_KILL), pcsrc codes (PCSRC_SEQ/BR/JMP), NOP constant.
- One sub-module, fetch_npc_sel: combinational next-PC priority mux.
- FSM and registers stay in fetch_unit.

Test Plan:
- Reset, imem_ready tied 1 -> imem_addr 0, 4, 8; if_inst valid every second cycle; if_pc4=if_pc+4.
- stall=1 in ST_VALID at pc=8 for 3 cycles -> pc, if_inst held, imem_req=0; after release, next address 12.
- pcsrc=01, bpc=32'h40 while in ST_REQ with imem_ready=0 -> ST_KILL, addr held at old pc until ready, data discarded, next request at 32'h40.
- intr and pcsrc=10 in the same cycle -> pc=EXC_VECTOR (8); jpc ignored; with FETCH_INTR_EN undefined -> pc=jpc.
- eret with epc=32'h100 during stall=1 -> redirect wins, fetch at 32'h100.
- pc=32'hFFFF_FFFC, stall=0 -> next pc 0, if_pc4 reads 0.
